// File: rtl/ysyx_23060077_clint_xbar_if.sv
// rtl/ysyx_23060077_clint_xbar_if.sv - AXI4 five-channel bus bundle with master/slave views
interface ysyx_23060077_clint_xbar_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_23060077_clint_xbar.sv
// rtl/ysyx_23060077_clint_xbar.sv - AXI4 1-to-2 router with internal CLINT mtime timer
module ysyx_23060077_clint_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic                             aclk,
    input  logic                             areset_n,
    ysyx_23060077_clint_xbar_if.slave        s,
    ysyx_23060077_clint_xbar_if.master       m
);
    localparam logic [31:0] WIN_MASK  = ~(CLINT_SIZE - 32'd1);
    localparam logic [12:0] MTIME_IDX = 13'h17FF;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int          DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_EXT  = 2'd1;
    localparam logic [1:0] R_INT  = 2'd2;

    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_EXT      = 2'd1;
    localparam logic [1:0] W_INT_DATA = 2'd2;
    localparam logic [1:0] W_INT_RESP = 2'd3;

    logic [1:0]  r_state, w_state;
    logic [3:0]  r_id, w_id;
    logic [7:0]  r_len, w_len, r_beat;
    logic [12:0] r_idx, w_idx;
    logic [63:0] r_snap;
    logic [63:0] mtime, mtime_merged;
    logic [DIV_W-1:0] div_cnt;
    logic        ar_hit, aw_hit, tick, mtime_wr;

    assign ar_hit   = (s.araddr & WIN_MASK) == CLINT_BASE;
    assign aw_hit   = (s.awaddr & WIN_MASK) == CLINT_BASE;
    assign tick     = (div_cnt == DIV_MAX);
    assign mtime_wr = (w_state == W_INT_DATA) && s.wvalid && (w_len == 8'd0) && (w_idx == MTIME_IDX);

    // Read path state: decode AR, track external burst or serve internal beats
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s.arvalid) begin
                    if (ar_hit) begin
                        r_state <= R_INT;
                        r_id    <= s.arid;
                        r_len   <= s.arlen;
                        r_idx   <= s.araddr[15:3];
                        r_snap  <= mtime;
                        r_beat  <= '0;
                    end else if (m.arready) begin
                        r_state <= R_EXT;
                    end
                end
                R_EXT: if (m.rvalid && s.rready && m.rlast) r_state <= R_IDLE;
                R_INT: if (s.rready) begin
                    r_beat <= r_beat + 8'd1;
                    if (r_beat == r_len) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Read path outputs: AR/R pass-through for external, generated beats for CLINT
    always_comb begin
        m.arvalid  = 1'b0;
        m.araddr   = s.araddr;
        m.arid     = s.arid;
        m.arlen    = s.arlen;
        m.arsize   = s.arsize;
        m.arburst  = s.arburst;
        m.rready   = 1'b0;
        s.arready  = 1'b0;
        s.rvalid   = 1'b0;
        s.rdata    = '0;
        s.rresp    = RESP_OKAY;
        s.rlast    = 1'b0;
        s.rid      = '0;
        case (r_state)
            R_IDLE: begin
                if (ar_hit) begin
                    s.arready = 1'b1;
                end else begin
                    m.arvalid = s.arvalid;
                    s.arready = m.arready;
                end
            end
            R_EXT: begin
                s.rvalid = m.rvalid;
                s.rdata  = m.rdata;
                s.rresp  = m.rresp;
                s.rlast  = m.rlast;
                s.rid    = m.rid;
                m.rready = s.rready;
            end
            R_INT: begin
                s.rvalid = 1'b1;
                s.rid    = r_id;
                s.rlast  = (r_beat == r_len);
                s.rdata  = (r_idx == MTIME_IDX) ? r_snap : 64'd0;
                s.rresp  = (r_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
            end
            default: ;
        endcase
    end

    // Write path state: decode AW, track external write or absorb CLINT data beats
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_len   <= '0;
            w_idx   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (s.awvalid) begin
                    if (aw_hit) begin
                        w_state <= W_INT_DATA;
                        w_id    <= s.awid;
                        w_len   <= s.awlen;
                        w_idx   <= s.awaddr[15:3];
                    end else if (m.awready) begin
                        w_state <= W_EXT;
                    end
                end
                W_EXT:      if (m.bvalid && s.bready) w_state <= W_IDLE;
                W_INT_DATA: if (s.wvalid && s.wlast)  w_state <= W_INT_RESP;
                W_INT_RESP: if (s.bready)             w_state <= W_IDLE;
                default:    w_state <= W_IDLE;
            endcase
        end
    end

    // Write path outputs: AW/W/B pass-through for external, local response for CLINT
    always_comb begin
        m.awvalid = 1'b0;
        m.awaddr  = s.awaddr;
        m.awid    = s.awid;
        m.awlen   = s.awlen;
        m.awsize  = s.awsize;
        m.awburst = s.awburst;
        m.wvalid  = 1'b0;
        m.wdata   = s.wdata;
        m.wstrb   = s.wstrb;
        m.wlast   = s.wlast;
        m.bready  = 1'b0;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        s.bresp   = RESP_OKAY;
        s.bid     = '0;
        case (w_state)
            W_IDLE: begin
                if (aw_hit) begin
                    s.awready = 1'b1;
                end else begin
                    m.awvalid = s.awvalid;
                    s.awready = m.awready;
                end
            end
            W_EXT: begin
                m.wvalid = s.wvalid;
                s.wready = m.wready;
                s.bvalid = m.bvalid;
                s.bresp  = m.bresp;
                s.bid    = m.bid;
                m.bready = s.bready;
            end
            W_INT_DATA: s.wready = 1'b1;
            W_INT_RESP: begin
                s.bvalid = 1'b1;
                s.bid    = w_id;
                s.bresp  = (w_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
            end
            default: ;
        endcase
    end

    // Byte-lane merge of incoming write data over the current timer value
    always_comb begin
        mtime_merged = mtime;
        for (int i = 0; i < 8; i++) begin
            if (s.wstrb[i]) mtime_merged[i*8 +: 8] = s.wdata[i*8 +: 8];
        end
    end

    // Tick divider free-runs; a timer write in the same cycle swallows that tick
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            div_cnt <= '0;
            mtime   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (mtime_wr)  mtime <= mtime_merged;
            else if (tick) mtime <= mtime + 64'd1;
        end
    end
endmodule

// File: tb/tb_ysyx_23060077_clint_xbar.sv
// tb/tb_ysyx_23060077_clint_xbar.sv - scoreboard bench for the CLINT crossbar
module tb_ysyx_23060077_clint_xbar;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    ysyx_23060077_clint_xbar_if s_if ();
    ysyx_23060077_clint_xbar_if m_if ();

    ysyx_23060077_clint_xbar dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s        (s_if),
        .m        (m_if)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rbeat_t rq[$];
    bexp_t  bq[$];
    rbeat_t r_exp;
    bexp_t  b_exp;
    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mdl;
    logic        mdl_wr = 1'b0;
    logic [63:0] mdl_wdata = '0;
    logic [7:0]  mdl_wstrb = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_clint(input logic [31:0] a);
        return (a & 32'hFFFF_0000) == 32'h0200_0000;
    endfunction

    // Reference timer: +1 per cycle, a strobed write replaces the increment
    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) mdl <= '0;
        else if (mdl_wr) begin
            for (int i = 0; i < 8; i++)
                mdl[i*8 +: 8] <= mdl_wstrb[i] ? mdl_wdata[i*8 +: 8] : mdl[i*8 +: 8];
        end else mdl <= mdl + 64'd1;
    end

    // Upstream monitor: every R/B handshake is popped against the scoreboard
    always @(negedge aclk) begin
        if (areset_n) begin
            if (s_if.rvalid && s_if.rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    r_exp = rq.pop_front();
                    check("rdata", s_if.rdata, r_exp.data);
                    check("rresp", 64'(s_if.rresp), 64'(r_exp.resp));
                    check("rlast", 64'(s_if.rlast), 64'(r_exp.last));
                    check("rid",   64'(s_if.rid),   64'(r_exp.id));
                end
            end
            if (s_if.bvalid && s_if.bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    b_exp = bq.pop_front();
                    check("bresp", 64'(s_if.bresp), 64'(b_exp.resp));
                    check("bid",   64'(s_if.bid),   64'(b_exp.id));
                end
            end
        end
    end

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        bit ok = 0;
        rbeat_t e;
        s_if.araddr = addr; s_if.arid = id; s_if.arlen = len;
        s_if.arsize = 3'd3; s_if.arburst = 2'd1; s_if.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            ok = s_if.arready;
            if (ok) break;
        end
        check("ar_accept", 64'(ok), 1);
        if (ok && is_clint(addr)) begin
            for (int b = 0; b <= int'(len); b++) begin
                e.data = (addr[15:3] == 13'h17FF) ? mdl : 64'd0;
                e.resp = (len == 8'd0) ? 2'b00 : 2'b10;
                e.last = (b == int'(len));
                e.id   = id;
                rq.push_back(e);
            end
        end
        @(posedge aclk); #1;
        s_if.arvalid = 1'b0;
    endtask

    task automatic r_drain();
        for (int i = 0; i < 50; i++) begin
            @(posedge aclk);
            if (rq.size() == 0) break;
        end
        #2;
        check("r_drain", 64'(rq.size()), 0);
    endtask

    task automatic int_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        ar_send(addr, id, len);
        @(negedge aclk);
        check("rd_latency", 64'(s_if.rvalid), 1);
        r_drain();
    endtask

    task automatic ext_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        rbeat_t e;
        fork
            ar_send(addr, id, len);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge aclk);
                    if (m_if.arvalid) break;
                end
                check("m_araddr", 64'(m_if.araddr), 64'(addr));
                check("m_arlen",  64'(m_if.arlen),  64'(len));
                @(posedge aclk); #1;
                for (int b = 0; b <= int'(len); b++) begin
                    m_if.rvalid = 1'b1;
                    m_if.rdata  = {$urandom, $urandom};
                    m_if.rid    = id;
                    m_if.rresp  = 2'(b);
                    m_if.rlast  = (b == int'(len));
                    e.data = m_if.rdata; e.resp = m_if.rresp; e.last = m_if.rlast; e.id = id;
                    rq.push_back(e);
                    for (int i = 0; i < 50; i++) begin
                        @(negedge aclk);
                        if (m_if.rready) break;
                    end
                    check("ext_arready_low", 64'(s_if.arready), 0);
                    @(posedge aclk); #1;
                end
                m_if.rvalid = 1'b0;
                m_if.rlast  = 1'b0;
            end
        join
        r_drain();
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [63:0] data, input logic [7:0] strb);
        bit ext = !is_clint(addr);
        bit ok;
        bexp_t be;
        fork
            begin
                s_if.awaddr = addr; s_if.awid = id; s_if.awlen = len;
                s_if.awsize = 3'd3; s_if.awburst = 2'd1; s_if.awvalid = 1'b1;
                ok = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge aclk);
                    ok = s_if.awready;
                    if (ok) break;
                end
                check("aw_accept", 64'(ok), 1);
                @(posedge aclk); #1;
                s_if.awvalid = 1'b0;
                for (int b = 0; b <= int'(len); b++) begin
                    s_if.wvalid = 1'b1; s_if.wdata = data; s_if.wstrb = strb;
                    s_if.wlast = (b == int'(len));
                    ok = 0;
                    for (int i = 0; i < 50; i++) begin
                        @(negedge aclk);
                        ok = s_if.wready;
                        if (ok) begin
                            if (!ext && b == 0) check("wr_latency", 64'(i), 0);
                            break;
                        end
                    end
                    check("w_accept", 64'(ok), 1);
                    if (!ext && len == 8'd0 && addr[15:3] == 13'h17FF) begin
                        mdl_wr = 1'b1; mdl_wdata = data; mdl_wstrb = strb;
                    end
                    @(posedge aclk); #1;
                    mdl_wr = 1'b0;
                end
                s_if.wvalid = 1'b0;
                s_if.wlast  = 1'b0;
                if (!ext) begin
                    be.resp = (len == 8'd0) ? 2'b00 : 2'b10;
                    be.id   = id;
                    bq.push_back(be);
                    @(negedge aclk);
                    check("b_latency", 64'(s_if.bvalid), 1);
                end else begin
                    for (int i = 0; i < 50; i++) begin
                        @(negedge aclk);
                        if (s_if.bvalid) break;
                    end
                end
                @(posedge aclk); #1;
                check("b_drain", 64'(bq.size()), 0);
            end
            if (ext) begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge aclk);
                    if (m_if.awvalid) break;
                end
                check("m_awaddr", 64'(m_if.awaddr), 64'(addr));
                for (int i = 0; i < 50; i++) begin
                    @(negedge aclk);
                    if (m_if.wvalid) break;
                end
                check("m_wdata", m_if.wdata, data);
                check("m_wstrb", 64'(m_if.wstrb), 64'(strb));
                @(posedge aclk); #1;
                m_if.bvalid = 1'b1; m_if.bid = id; m_if.bresp = 2'b01;
                be.resp = 2'b01; be.id = id;
                bq.push_back(be);
                for (int i = 0; i < 50; i++) begin
                    @(negedge aclk);
                    if (m_if.bready) break;
                end
                @(posedge aclk); #1;
                m_if.bvalid = 1'b0;
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        s_if.awvalid = 0; s_if.awaddr = 0; s_if.awid = 0; s_if.awlen = 0; s_if.awsize = 0; s_if.awburst = 0;
        s_if.wvalid = 0; s_if.wdata = 0; s_if.wstrb = 0; s_if.wlast = 0; s_if.bready = 1;
        s_if.arvalid = 0; s_if.araddr = 0; s_if.arid = 0; s_if.arlen = 0; s_if.arsize = 0; s_if.arburst = 0;
        s_if.rready = 1;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0; m_if.bid = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rlast = 0; m_if.rid = 0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_arready", 64'(s_if.arready), 0);
        check("rst_awready", 64'(s_if.awready), 0);
        check("rst_wready",  64'(s_if.wready), 0);
        check("rst_rvalid",  64'(s_if.rvalid), 0);
        check("rst_bvalid",  64'(s_if.bvalid), 0);
        check("rst_m_arvalid", 64'(m_if.arvalid), 0);
        check("rst_m_awvalid", 64'(m_if.awvalid), 0);
        check("rst_rdata",   s_if.rdata, 0);
        m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
        areset_n = 1'b1;
        repeat (4) @(posedge aclk);
        #1;

        int_read(32'h0200_BFF8, 4'h3, 8'd0);
        write_txn(32'h0200_BFF8, 4'h5, 8'd0, 64'h0000_0001_FFFF_FFF0, 8'hFF);
        for (int k = 0; k < 8; k++) int_read(32'h0200_BFF8, 4'(k), 8'd0);
        int_read(32'h0200_BFFC, 4'hA, 8'd0);

        write_txn(32'h0200_BFFC, 4'h6, 8'd0, 64'hAAAA_BBBB_0000_0000, 8'hF0);
        int_read(32'h0200_BFF8, 4'h1, 8'd0);

        ext_read(32'h8000_0000, 4'h9, 8'd3);
        int_read(32'h0200_BFF8, 4'h2, 8'd1);
        int_read(32'h0200_4000, 4'h4, 8'd0);

        fork
            ext_read(32'h8000_1000, 4'h6, 8'd1);
            write_txn(32'h0200_BFF8, 4'h7, 8'd0, 64'h0000_0000_0000_1234, 8'hFF);
        join
        int_read(32'h0200_BFF8, 4'h8, 8'd0);

        write_txn(32'h8000_2000, 4'hB, 8'd0, 64'hDEAD_BEEF_0123_4567, 8'h0F);
        write_txn(32'h0200_BFF8, 4'hC, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        int_read(32'h0200_BFF8, 4'hD, 8'd0);

        s_if.rready = 1'b0;
        ar_send(32'h0200_BFF8, 4'hE, 8'd0);
        @(negedge aclk);
        check("pre_rst_rvalid", 64'(s_if.rvalid), 1);
        #1 areset_n = 1'b0;
        #1 check("mid_rst_rvalid", 64'(s_if.rvalid), 0);
        rq.delete();
        @(posedge aclk); #1;
        areset_n = 1'b1;
        s_if.rready = 1'b1;
        int_read(32'h0200_BFF8, 4'hF, 8'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("end_rq_empty", 64'(rq.size()), 0);
        check("end_bq_empty", 64'(bq.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060077_clint_xbar.md
# ysyx_23060077_clint_xbar

AXI4 1-to-2 router placed directly downstream of the core's AXI arbiter and upstream of the `io_master_*` pins. It decodes every read and write address. Accesses inside the CLINT window are served by an internal 64-bit `mtime` timer. All other accesses are forwarded unchanged to the external master port. Each direction (read, write) carries at most one outstanding transaction, matching what the arbiter issues.

## Interface
Parameters:
- `CLINT_BASE`, default 32'h0200_0000: base address of the CLINT window.
- `CLINT_SIZE`, default 32'h0001_0000: window size in bytes (power of two). Hit when `(addr & ~(CLINT_SIZE-1)) == CLINT_BASE`.
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` cycles (must be ≥1).

Ports (all channel fields follow AXI4 widths: addr 32, id 4, len 8, size 3, burst 2, data 64, strb 8, resp 2):
- `aclk`, input, 1: clock.
- `areset_n`, input, 1: asynchronous, active-low reset.
- `s_aw{valid,addr,id,len,size,burst}` in / `s_awready` out: upstream write-address channel.
- `s_w{valid,data,strb,last}` in / `s_wready` out: upstream write-data channel.
- `s_b{valid,resp,id}` out / `s_bready` in: upstream write-response channel.
- `s_ar{valid,addr,id,len,size,burst}` in / `s_arready` out: upstream read-address channel.
- `s_r{valid,data,resp,last,id}` out / `s_rready` in: upstream read-data channel.
- `m_*`: the same five channels with directions mirrored, connected to `io_master_*`.

## Operation
Read FSM (`R_IDLE`, `R_EXT`, `R_INT`):
- `R_IDLE`, external address:
  - `m_arvalid = s_arvalid`, `s_arready = m_arready`, all AR fields passed through.
  - On handshake, go to `R_EXT`.
- `R_IDLE`, CLINT address:
  - `s_arready = 1`, `m_arvalid = 0`.
  - On handshake, latch id, len and offset; snapshot `mtime`; clear the beat counter; go to `R_INT`.
- `R_EXT`:
  - R channel is passed through: `m_rready = s_rready`.
  - Go to `R_IDLE` on a beat with `m_rvalid & s_rready & m_rlast`.
  - `s_arready = 0` while in this state.
- `R_INT`:
  - `s_rvalid = 1`, `s_rid` = latched id, `s_rlast = (beat == len)`.
  - `s_rdata`: equals the snapshot when offset[15:3] == 13'h17FF (0xBFF8 or 0xBFFC; the 64-bit lane placement covers both halves). Otherwise 0.
  - `s_rresp`: OKAY when len == 0, SLVERR when len > 0. A burst still returns len+1 beats.
  - Each beat with `s_rready` increments the counter. The last beat returns the FSM to `R_IDLE`.

Write FSM (`W_IDLE`, `W_EXT`, `W_INT_DATA`, `W_INT_RESP`):
- `W_IDLE`: AW decoded the same way as AR.
  - External: pass-through, go to `W_EXT`.
  - CLINT: `s_awready = 1`, latch fields, go to `W_INT_DATA`.
  - `s_wready = 0` in `W_IDLE`.
- `W_EXT`:
  - W and B channels are passed through.
  - Return to `W_IDLE` on the B handshake.
- `W_INT_DATA`:
  - `s_wready = 1`.
  - On each beat with len == 0 at offset 0xBFF8/0xBFFC, write `mtime` byte lanes selected by `s_wstrb`.
  - The `s_wlast` beat moves the FSM to `W_INT_RESP`.
- `W_INT_RESP`:
  - `s_bvalid = 1`, `s_bid` = latched id, `s_bresp` OKAY (SLVERR if len > 0; no write occurs).
  - Go to `W_IDLE` on `s_bready`.

Timer:
- A divider counts 0..`TICK_DIV`-1; `mtime` increments by 1 on wrap.
- A write takes priority in its cycle: strobed bytes take the write data, unstrobed bytes hold their current value, and there is no increment that cycle.
- `mtime` wraps 2^64-1 → 0.
- Reads and writes are independent. A read snapshot taken in the same cycle as a write captures the pre-write value.

## Timing
- Reset values:
  - All `s_*valid`, `s_*ready`, `m_*valid`, `m_*ready` = 0 (ready signals only as driven by FSM state, which resets to idle).
  - Data and resp outputs = 0; FSMs idle; `mtime` = 0; divider = 0.
- Reset asserted mid-transaction aborts it: FSMs go to idle immediately and no response is issued.
- External path adds zero cycles: the AR/AW decode and all pass-through signals are combinational.
- Internal read: AR handshake in cycle N → `s_rvalid` in N+1. Back-to-back beats occur every cycle while `s_rready` is held.
- Internal write: AW handshake in N → `s_wready` in N+1. `s_wlast` handshake in M → `s_bvalid` in M+1; `mtime` shows the written value in M+1.
- A read and a write may be in flight at once, one on each path.

## Test plan
- Reset, `TICK_DIV`=1, read 0x0200_BFF8 size 3 at N: `s_rdata` at N+1 = snapshot, which is N-cycle count since reset; `rresp` 0, `rlast` 1.
- Write 0x0200_BFF8, data 64'h0000_0001_FFFF_FFF0, strb 8'hFF; then read repeatedly: value counts up and carries into the high word after 16 cycles.
- Write 0x0200_BFFC, strb 8'hF0, data 64'hAAAA_BBBB_0000_0000: high word becomes 0xAAAABBBB, low word unaffected apart from continuing to count.
- Read 0x8000_0000 len 3 with external slave returning 4 beats: all beats, ids and `rlast` forwarded unchanged; `s_arready` = 0 until the last beat.
- CLINT read len 1: two beats, both SLVERR, `rlast` only on the second. Then a CLINT write len 0 concurrent with an external read: both complete correctly.
- Assert `areset_n` low during `R_INT` with `s_rready` = 0: `s_rvalid` drops immediately and `mtime` = 0.
